psram_arbiter: RTL and testbench

PSRAM_ARBITER -- requirements
Module: psram_arbiter

---
 rtl/psram_pkg.sv | 15 +
 rtl/psram_arbiter.sv | 139 +++++++++++++
 tb/tb_psram_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_pkg.sv
// Shared state encoding and default sizing for the PSRAM arbiter.
package psram_pkg;

    localparam int DEF_WAIT_CYCLES = 4;
    localparam int DEF_ADDR_W      = 23;
    localparam int DATA_W          = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } psram_state_e;

endpackage

// File: rtl/psram_arbiter.sv
// Round-robin arbiter between a write-only capture port and a read/write host
// port, driving one asynchronous PSRAM with a fixed SETUP/ACCESS/HOLD cycle.
//
// state  | meaning
// IDLE   | bus released, pick a winner among pending requests
// SETUP  | chip selected, address/byte enables (and write data) driven
// ACCESS | nwe or noe0 asserted for WAIT_CYCLES cycles
// HOLD   | strobes released, address/data held, winner's done pulse
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic              CLK50,
    input  logic              RESET,
    input  logic              capt_req,
    input  logic [ADDR_W-1:0] capt_addr,
    input  logic [DATA_W-1:0] capt_wdata,
    output logic              capt_done,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [1:0]        host_be,
    output logic              host_done,
    output logic [DATA_W-1:0] host_rdata,
    output logic              psram_ncs0,
    output logic              psram_nwe,
    output logic              psram_noe0,
    output logic [1:0]        psram_nbyte_en,
    output logic [ADDR_W-1:0] psram_address,
    output logic [DATA_W-1:0] psram_dq_out,
    output logic              psram_dq_oe,
    input  logic [DATA_W-1:0] psram_dq_in
);

    localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("WAIT_CYCLES must be at least 1");
    end

    psram_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_host_q;
    logic             lat_host_q;
    logic             lat_we_q;
    logic [1:0]       lat_nbe_q;

    logic             grant;
    logic             grant_host;
    logic             next_we;
    logic [1:0]       next_nbe;
    logic             last_access;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant      = 1'b0;
        grant_host = 1'b0;
        case (state_q)
            IDLE: begin
                if (capt_req || host_req) begin
                    grant = 1'b1;
                    // on a tie the port not served last wins
                    grant_host = host_req && (!capt_req || !last_host_q);
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CNT_LOAD;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign next_we     = grant ? (grant_host ? host_we : 1'b1) : lat_we_q;
    assign next_nbe    = grant ? (grant_host ? ~host_be : 2'b00) : lat_nbe_q;
    assign last_access = (state_q == ACCESS) && (cnt_q == '0);

    // Pins are registered from the next state so they line up with state_q.
    always_ff @(posedge CLK50) begin
        if (RESET) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            last_host_q    <= 1'b1;
            lat_host_q     <= 1'b0;
            lat_we_q       <= 1'b0;
            lat_nbe_q      <= 2'b11;
            psram_ncs0     <= 1'b1;
            psram_nwe      <= 1'b1;
            psram_noe0     <= 1'b1;
            psram_nbyte_en <= 2'b11;
            psram_dq_oe    <= 1'b0;
            psram_address  <= '0;
            psram_dq_out   <= '0;
            capt_done      <= 1'b0;
            host_done      <= 1'b0;
            host_rdata     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                last_host_q   <= grant_host;
                lat_host_q    <= grant_host;
                lat_we_q      <= next_we;
                lat_nbe_q     <= next_nbe;
                psram_address <= grant_host ? host_addr : capt_addr;
                psram_dq_out  <= grant_host ? host_wdata : capt_wdata;
            end
            psram_ncs0     <= (state_d == IDLE);
            psram_nwe      <= !((state_d == ACCESS) && lat_we_q);
            psram_noe0     <= !((state_d == ACCESS) && !lat_we_q);
            psram_nbyte_en <= (state_d == IDLE) ? 2'b11 : next_nbe;
            psram_dq_oe    <= (state_d != IDLE) && next_we;
            capt_done      <= (state_d == HOLD) && !lat_host_q;
            host_done      <= (state_d == HOLD) && lat_host_q;
            if (last_access && !lat_we_q) begin
                host_rdata <= psram_dq_in;
            end
        end
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter: a WAIT_CYCLES=4 instance for the main
// directed cases and a WAIT_CYCLES=1 instance for back-to-back throughput.
module tb_psram_arbiter;
    import psram_pkg::*;

    localparam int AW   = 23;
    localparam int WAIT = 4;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic reset = 1'b1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          capt_req = 0, capt_done, host_req = 0, host_we = 0, host_done;
    logic [AW-1:0] capt_addr = '0, host_addr = '0, psram_address;
    logic [15:0]   capt_wdata = '0, host_wdata = '0, host_rdata, psram_dq_out, psram_dq_in;
    logic [1:0]    host_be = 2'b11, psram_nbyte_en;
    logic          psram_ncs0, psram_nwe, psram_noe0, psram_dq_oe;
    logic [15:0]   rd_val = 16'h0000;

    assign psram_dq_in = psram_noe0 ? 16'hDEAD : rd_val;

    psram_arbiter #(.WAIT_CYCLES(WAIT), .ADDR_W(AW)) dut (
        .CLK50(clk), .RESET(reset),
        .capt_req(capt_req), .capt_addr(capt_addr), .capt_wdata(capt_wdata), .capt_done(capt_done),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_be(host_be), .host_done(host_done), .host_rdata(host_rdata),
        .psram_ncs0(psram_ncs0), .psram_nwe(psram_nwe), .psram_noe0(psram_noe0),
        .psram_nbyte_en(psram_nbyte_en), .psram_address(psram_address),
        .psram_dq_out(psram_dq_out), .psram_dq_oe(psram_dq_oe), .psram_dq_in(psram_dq_in)
    );

    logic          capt_req_1 = 0, capt_done_1, host_done_1;
    logic [AW-1:0] capt_addr_1 = '0, psram_address_1;
    logic [15:0]   capt_wdata_1 = '0, host_rdata_1, psram_dq_out_1;
    logic [1:0]    psram_nbyte_en_1;
    logic          psram_ncs0_1, psram_nwe_1, psram_noe0_1, psram_dq_oe_1;

    psram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(AW)) dut_w1 (
        .CLK50(clk), .RESET(reset),
        .capt_req(capt_req_1), .capt_addr(capt_addr_1), .capt_wdata(capt_wdata_1), .capt_done(capt_done_1),
        .host_req(1'b0), .host_we(1'b0), .host_addr('0), .host_wdata(16'h0000),
        .host_be(2'b00), .host_done(host_done_1), .host_rdata(host_rdata_1),
        .psram_ncs0(psram_ncs0_1), .psram_nwe(psram_nwe_1), .psram_noe0(psram_noe0_1),
        .psram_nbyte_en(psram_nbyte_en_1), .psram_address(psram_address_1),
        .psram_dq_out(psram_dq_out_1), .psram_dq_oe(psram_dq_oe_1), .psram_dq_in(16'h1234)
    );

    int checks = 0;
    int passed = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    typedef struct {
        logic          host;
        int            cyc;
        logic [AW-1:0] addr;
        logic [1:0]    nbe;
        logic          we;
        logic [15:0]   wdata;
        logic [15:0]   rdata;
    } exp_t;

    exp_t sb_q[$];
    int   exp1_q[$];

    // Bus-contention watch on both instances, reported once at the end.
    int ovl_viol = 0;
    always @(negedge clk) begin
        assert (!(psram_dq_oe && !psram_noe0)) else ovl_viol++;
        assert (!(psram_dq_oe_1 && !psram_noe0_1)) else ovl_viol++;
    end

    int   n_cs = 0, n_we = 0, n_oe = 0, n_dqoe = 0, n_nbe_bad = 0;
    exp_t e_m;
    always @(negedge clk) begin
        if (!psram_ncs0) begin
            n_cs++;
            if (!psram_nwe) n_we++;
            if (!psram_noe0) n_oe++;
            if (psram_dq_oe) n_dqoe++;
            if (sb_q.size() > 0 && psram_nbyte_en !== sb_q[0].nbe) n_nbe_bad++;
        end
        if (capt_done || host_done) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done_queue_size", 32'(sb_q.size()), 1);
            end else begin
                e_m = sb_q.pop_front();
                chk("done_port_host", host_done, e_m.host);
                chk("done_port_capt", capt_done, !e_m.host);
                chk("done_cycle", cyc, e_m.cyc);
                chk("hold_address", psram_address, e_m.addr);
                chk("hold_nbyte_en", psram_nbyte_en, e_m.nbe);
                chk("ncs0_low_cycles", n_cs, WAIT + 2);
                chk("nwe_low_cycles", n_we, e_m.we ? WAIT : 0);
                chk("noe0_low_cycles", n_oe, e_m.we ? 0 : WAIT);
                chk("dq_oe_high_cycles", n_dqoe, e_m.we ? WAIT + 2 : 0);
                chk("nbyte_en_stable", n_nbe_bad, 0);
                if (e_m.we) chk("hold_dq_out", psram_dq_out, e_m.wdata);
                else        chk("read_rdata", host_rdata, e_m.rdata);
            end
        end
        if (psram_ncs0 || capt_done || host_done) begin
            n_cs = 0; n_we = 0; n_oe = 0; n_dqoe = 0; n_nbe_bad = 0;
        end
    end

    int e1;
    always @(negedge clk) begin
        if (capt_done_1 || host_done_1) begin
            if (exp1_q.size() == 0) begin
                chk("w1_spurious_done_queue_size", 32'(exp1_q.size()), 1);
            end else begin
                e1 = exp1_q.pop_front();
                chk("w1_done_cycle", cyc, e1);
                chk("w1_done_port_host", host_done_1, 0);
            end
        end
    end

    task automatic run_access(input bit is_host, input bit we, input logic [AW-1:0] a,
                              input logic [15:0] d, input logic [1:0] be, input logic [15:0] rd);
        exp_t e;
        bit   seen;
        @(posedge clk); #1;
        rd_val = rd;
        if (is_host) begin
            host_we = we; host_addr = a; host_wdata = d; host_be = be; host_req = 1'b1;
        end else begin
            capt_addr = a; capt_wdata = d; capt_req = 1'b1;
        end
        e.host  = is_host;
        e.cyc   = cyc + WAIT + 2;
        e.addr  = a;
        e.nbe   = is_host ? ~be : 2'b00;
        e.we    = is_host ? we : 1'b1;
        e.wdata = d;
        e.rdata = rd;
        sb_q.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = is_host ? host_done : capt_done;
        end
        chk(is_host ? "host_done_seen" : "capt_done_seen", seen, 1);
        @(posedge clk); #1;
        capt_req = 1'b0;
        host_req = 1'b0;
    endtask

    // Both ports hold req for the whole run; grants must alternate, capture first.
    task automatic run_both(input int rounds, input logic [AW-1:0] ac, input logic [15:0] dc,
                            input logic [AW-1:0] ah, input logic [15:0] dh);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        capt_addr = ac; capt_wdata = dc;
        host_we = 1'b1; host_addr = ah; host_wdata = dh; host_be = 2'b11;
        for (int r = 0; r < rounds; r++) begin
            e.host  = (r % 2 == 1);
            e.cyc   = cyc + WAIT + 2 + (WAIT + 3) * r;
            e.addr  = e.host ? ah : ac;
            e.nbe   = 2'b00;
            e.we    = 1'b1;
            e.wdata = e.host ? dh : dc;
            e.rdata = 16'h0000;
            sb_q.push_back(e);
        end
        capt_req = 1'b1;
        host_req = 1'b1;
        n = 0;
        for (int i = 0; i < rounds * (WAIT + 3) + 20 && n < rounds; i++) begin
            @(negedge clk);
            if (capt_done || host_done) n++;
        end
        chk("pair_done_count", n, rounds);
        @(posedge clk); #1;
        capt_req = 1'b0;
        host_req = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ncs0", psram_ncs0, 1);
        chk("rst_nwe", psram_nwe, 1);
        chk("rst_noe0", psram_noe0, 1);
        chk("rst_nbyte_en", psram_nbyte_en, 2'b11);
        chk("rst_dq_oe", psram_dq_oe, 0);
        chk("rst_address", psram_address, 0);
        chk("rst_dq_out", psram_dq_out, 0);
        chk("rst_dones", {capt_done, host_done}, 0);
        chk("rst_host_rdata", host_rdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_access(1'b0, 1'b1, 23'h000123, 16'hBEEF, 2'b11, 16'h0000);
        run_access(1'b1, 1'b0, 23'h7ABCDE, 16'h0000, 2'b11, 16'h5A5A);
        run_access(1'b1, 1'b1, 23'h000456, 16'hC3C3, 2'b10, 16'h0000);
        run_access(1'b1, 1'b1, 23'h000789, 16'h1111, 2'b00, 16'h0000);
        chk("host_rdata_held_after_writes", host_rdata, 16'h5A5A);

        run_both(4, 23'h001000, 16'hAAAA, 23'h002000, 16'h5555);
        chk("host_rdata_held_after_pair", host_rdata, 16'h5A5A);

        // Abort a capture write with RESET during its second ACCESS cycle.
        @(posedge clk); #1;
        capt_addr = 23'h003000; capt_wdata = 16'hF00D; capt_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_in_access_nwe", psram_nwe, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        capt_req = 1'b0;
        @(negedge clk);
        chk("abort_ncs0", psram_ncs0, 1);
        chk("abort_nwe", psram_nwe, 1);
        chk("abort_dq_oe", psram_dq_oe, 0);
        chk("abort_capt_done", capt_done, 0);
        repeat (8) @(negedge clk);
        run_both(2, 23'h004000, 16'h0F0F, 23'h005000, 16'hF0F0);

        // WAIT_CYCLES=1 instance, capture requests held back-to-back.
        @(posedge clk); #1;
        capt_addr_1 = 23'h000042; capt_wdata_1 = 16'h4242;
        for (int r = 0; r < 4; r++) exp1_q.push_back(cyc + 3 + 4 * r);
        capt_req_1 = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (capt_done_1) n++;
        end
        chk("w1_done_count", n, 4);
        @(posedge clk); #1;
        capt_req_1 = 1'b0;

        repeat (6) @(negedge clk);
        chk("no_dq_oe_with_noe0_low", ovl_viol, 0);
        chk("scoreboard_drained", 32'(sb_q.size()), 0);
        chk("w1_scoreboard_drained", 32'(exp1_q.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
